// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 64-bit LEGv8 pipeline.
// Owns the PC. Handles hazard stalls and EX redirects (redirects flush IF/ID to a bubble).
// A sticky halt is raised when the B #0 self-loop is captured.
module if_id_fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INSTR  = 32'hD503201F,
  parameter logic [31:0] HALT_INSTR = 32'h14000000,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [63:0]          br_target,
  output logic [63:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [63:0]          pc,
  output logic [31:0]          id_instr,
  output logic [63:0]          id_pc,
  output logic                 id_valid,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam logic [63:0] PC_STEP    = 64'd4;
  localparam logic [63:0] ALIGN_MASK = ~64'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [63:0]          r_pc;
  logic [63:0]          w_pc_nxt;
  logic [31:0]          r_id_instr;
  logic [31:0]          w_id_instr_nxt;
  logic [63:0]          r_id_pc;
  logic [63:0]          w_id_pc_nxt;
  logic                 r_id_valid;
  logic                 w_id_valid_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  // State and pipeline registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= 64'd0;
      r_id_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Next-state: halt drains to a bubble, redirect beats stall, otherwise capture and advance.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_instr_nxt = r_id_instr;
    w_id_pc_nxt    = r_id_pc;
    w_id_valid_nxt = r_id_valid;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      ST_HALT: begin
        w_id_instr_nxt = NOP_INSTR;
        w_id_valid_nxt = 1'b0;
      end
      ST_RUN: begin
        if (br_taken) begin
          w_pc_nxt       = br_target & ALIGN_MASK;
          w_id_instr_nxt = NOP_INSTR;
          w_id_pc_nxt    = 64'd0;
          w_id_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_pc_nxt       = r_pc + PC_STEP;
          w_id_instr_nxt = imem_rdata;
          w_id_pc_nxt    = r_pc;
          w_id_valid_nxt = 1'b1;
          if (r_cnt != {CNT_WIDTH{1'b1}}) begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
          end
          if (imem_rdata == HALT_INSTR) begin
            w_state_nxt = ST_HALT;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_valid    = r_id_valid;
  assign halted      = (r_state == ST_HALT);
  assign fetch_count = r_cnt;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: a directed vector table, a wrap/saturation sequence,
// and random stimulus checked against a behavioural model. Two instances share
// stimulus; the second uses a 2-bit fetch counter to exercise saturation.
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP  = 32'hD503201F;
  localparam logic [31:0] HALT = 32'h14000000;
  localparam logic [31:0] ADDI = 32'h8B020020;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [63:0] br_target;
  logic        mem_mode;

  logic [63:0] a_addr, a_pc, a_id_pc;
  logic [31:0] a_rdata, a_id_instr;
  logic        a_id_valid, a_halted;
  logic [31:0] a_cnt;

  logic [63:0] b_addr, b_pc, b_id_pc;
  logic [31:0] b_rdata, b_id_instr;
  logic        b_id_valid, b_halted;
  logic [1:0]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [63:0] m_pc, m_id_pc;
  logic [31:0] m_instr;
  logic        m_valid, m_halted, m_idpc_known;
  longint      m_cnt;

  always #5 clk = ~clk;

  // Instruction memory image: mode 0 = constant ADD with HALT at 0x20, mode 1 = address hash.
  function automatic logic [31:0] imem_f(input logic [63:0] a, input logic m);
    if (!m) return (a == 64'h20) ? HALT : ADDI;
    if (a[6:2] == 5'd7) return HALT;
    return a[31:0] ^ 32'h5A5A0F0F;
  endfunction

  assign a_rdata = imem_f(a_addr, mem_mode);
  assign b_rdata = imem_f(b_addr, mem_mode);

  if_id_fetch_stage u_dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_addr(a_addr), .imem_rdata(a_rdata), .pc(a_pc), .id_instr(a_id_instr),
    .id_pc(a_id_pc), .id_valid(a_id_valid), .halted(a_halted), .fetch_count(a_cnt)
  );

  if_id_fetch_stage #(.CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_addr(b_addr), .imem_rdata(b_rdata), .pc(b_pc), .id_instr(b_id_instr),
    .id_pc(b_id_pc), .id_valid(b_id_valid), .halted(b_halted), .fetch_count(b_cnt)
  );

  typedef struct {
    logic        rst, st, br;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic [63:0] idpc;
    logic        chk_idpc;
    logic        valid;
    logic [31:0] instr;
    logic        halted;
    int unsigned cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [63:0] e_pc, input logic [63:0] e_idpc,
                           input logic e_chk_idpc, input logic e_valid, input logic [31:0] e_instr,
                           input logic e_halted, input longint e_cnt);
    longint sat;
    sat = (e_cnt > 3) ? 3 : e_cnt;
    chk({tag, " pc"},        a_pc,       e_pc);
    chk({tag, " imem_addr"}, a_addr,     e_pc);
    chk({tag, " id_instr"},  64'(a_id_instr), 64'(e_instr));
    chk({tag, " id_valid"},  64'(a_id_valid), 64'(e_valid));
    chk({tag, " halted"},    64'(a_halted),   64'(e_halted));
    chk({tag, " count"},     64'(a_cnt),      64'(e_cnt));
    if (e_chk_idpc) chk({tag, " id_pc"}, a_id_pc, e_idpc);
    chk({tag, " sat pc"},       b_pc,       e_pc);
    chk({tag, " sat id_instr"}, 64'(b_id_instr), 64'(e_instr));
    chk({tag, " sat id_valid"}, 64'(b_id_valid), 64'(e_valid));
    chk({tag, " sat halted"},   64'(b_halted),   64'(e_halted));
    chk({tag, " sat count"},    64'(b_cnt),      64'(sat));
    if (e_chk_idpc) chk({tag, " sat id_pc"}, b_id_pc, e_idpc);
  endtask

  // One posedge of the behavioural model, following the fetch-stage rules directly.
  task automatic model_step(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
    logic [31:0] rd;
    rd = imem_f(m_pc, mem_mode);
    if (rst) begin
      m_pc = 64'h0; m_instr = NOP; m_id_pc = 64'h0; m_valid = 1'b0;
      m_halted = 1'b0; m_cnt = 0; m_idpc_known = 1'b1;
    end else if (m_halted) begin
      m_instr = NOP; m_valid = 1'b0; m_idpc_known = 1'b0;
    end else if (br) begin
      m_pc = {tgt[63:2], 2'b00}; m_instr = NOP; m_id_pc = 64'h0; m_valid = 1'b0;
      m_idpc_known = 1'b1;
    end else if (!st) begin
      m_id_pc = m_pc; m_instr = rd; m_valid = 1'b1; m_idpc_known = 1'b1;
      m_cnt = m_cnt + 1;
      m_pc = m_pc + 64'd4;
      if (rd == HALT) m_halted = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic drive(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
    reset = rst; stall = st; br_taken = br; br_target = tgt;
    model_step(rst, st, br, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_pc, m_id_pc, m_idpc_known, m_valid, m_instr, m_halted, m_cnt);
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 64'h0; mem_mode = 1'b0;
    m_pc = 64'h0; m_instr = NOP; m_id_pc = 64'h0; m_valid = 1'b0;
    m_halted = 1'b0; m_cnt = 0; m_idpc_known = 1'b1;

    //                rst st  br  tgt        pc         idpc      chk valid instr halt cnt
    tbl.push_back('{1'b1,1'b0,1'b0,64'h0,   64'h0,   64'h0,   1'b1,1'b0,NOP, 1'b0,0});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h4,   64'h0,   1'b1,1'b1,ADDI,1'b0,1});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h8,   64'h4,   1'b1,1'b1,ADDI,1'b0,2});
    tbl.push_back('{1'b0,1'b1,1'b0,64'h0,   64'h8,   64'h4,   1'b1,1'b1,ADDI,1'b0,2});
    tbl.push_back('{1'b0,1'b1,1'b0,64'h0,   64'h8,   64'h4,   1'b1,1'b1,ADDI,1'b0,2});
    tbl.push_back('{1'b0,1'b1,1'b0,64'h0,   64'h8,   64'h4,   1'b1,1'b1,ADDI,1'b0,2});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'hC,   64'h8,   1'b1,1'b1,ADDI,1'b0,3});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h10,  64'hC,   1'b1,1'b1,ADDI,1'b0,4});
    tbl.push_back('{1'b0,1'b1,1'b1,64'h103, 64'h100, 64'h0,   1'b1,1'b0,NOP, 1'b0,4});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h104, 64'h100, 1'b1,1'b1,ADDI,1'b0,5});
    tbl.push_back('{1'b0,1'b0,1'b1,64'h22,  64'h20,  64'h0,   1'b1,1'b0,NOP, 1'b0,5});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h24,  64'h20,  1'b1,1'b1,HALT,1'b1,6});
    tbl.push_back('{1'b0,1'b1,1'b1,64'h200, 64'h24,  64'h0,   1'b0,1'b0,NOP, 1'b1,6});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h24,  64'h0,   1'b0,1'b0,NOP, 1'b1,6});
    tbl.push_back('{1'b1,1'b0,1'b0,64'h0,   64'h0,   64'h0,   1'b1,1'b0,NOP, 1'b0,0});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h4,   64'h0,   1'b1,1'b1,ADDI,1'b0,1});
    tbl.push_back('{1'b1,1'b1,1'b0,64'h0,   64'h0,   64'h0,   1'b1,1'b0,NOP, 1'b0,0});
    tbl.push_back('{1'b0,1'b0,1'b0,64'h0,   64'h4,   64'h0,   1'b1,1'b1,ADDI,1'b0,1});

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].br, tbl[i].tgt);
      check_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].idpc, tbl[i].chk_idpc,
                tbl[i].valid, tbl[i].instr, tbl[i].halted, longint'(tbl[i].cnt));
    end

    // PC wrap at the top of the address space and counter saturation.
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    check_model("wrap reset");
    drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap redirect pc", a_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      check_model($sformatf("wrap step%0d", k));
      if (k == 0) begin
        chk("wrap pc zero", a_pc, 64'h0);
        chk("wrap id_pc", a_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      end
    end
    chk("sat count 3", 64'(b_cnt), 64'd3);
    chk("full count 5", 64'(a_cnt), 64'd5);

    // Random stimulus against the model.
    mem_mode = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    check_model("rand reset");
    for (int k = 0; k < 600; k++) begin
      logic r, s, b;
      logic [63:0] t;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = {$urandom, $urandom};
      if (m_halted && $urandom_range(0, 5) == 0) r = 1'b1;
      drive(r, s, b, t);
      check_model($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 64-bit pipelined LEGv8 CPU. It sits directly upstream of the register-fetch stage.
- Owns the PC register and drives the instruction-memory address. It captures each fetched instruction with its PC into the IF/ID register.
- Applies stall from the hazard unit and branch redirect from EX. Redirect inserts a NOP bubble. A sticky halt is detected on the self-loop branch.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
NOP_INSTR, 32'hD503201F, encoding placed in id_instr for a bubble
HALT_INSTR, 32'h14000000, B #0 encoding that triggers halt
CNT_WIDTH, 32, width of the fetch counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high
stall  input  1  hold PC and IF/ID contents this cycle
br_taken  input  1  redirect from EX this cycle
br_target  input  64  redirect PC; bits [1:0] treated as 0
imem_addr  output  64  instruction memory address, equals current PC
imem_rdata  input  32  instruction at imem_addr, combinational same-cycle read
pc  output  64  current PC register value
id_instr  output  32  IF/ID instruction
id_pc  output  64  PC of id_instr
id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
halted  output  1  sticky halt flag
fetch_count  output  CNT_WIDTH  count of instructions captured valid into IF/ID; saturates

Behaviour:
- Reset, applied at posedge with reset=1:
  - pc=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_valid=0, halted=0, fetch_count=0.
  - Reset overrides every other input, including mid-halt and mid-stall.
- imem_addr = pc at all times. The fetch reads combinationally, and the IF/ID capture has 1-cycle latency.
- Per-posedge priority when reset=0:
  1. halted=1:
     - pc holds; id_instr=NOP_INSTR; id_valid=0; fetch_count holds.
     - stall and br_taken are ignored.
  2. br_taken=1 (wins over stall):
     - pc <= {br_target[63:2],2'b00}.
     - IF/ID flushed: id_instr=NOP_INSTR, id_valid=0, id_pc=0.
     - The instruction fetched this cycle is discarded and not counted.
  3. stall=1:
     - pc, id_instr, id_pc, id_valid and fetch_count all hold.
  4. Normal:
     - pc <= pc+4, with modulo 2^64 wrap (64'hFFFF_FFFF_FFFF_FFFC -> 0).
     - id_instr <= imem_rdata; id_pc <= pc; id_valid <= 1.
     - fetch_count increments by 1, saturating at all-ones.
- Halt detection:
  - Trigger: a normal capture with imem_rdata==HALT_INSTR.
  - That capture proceeds as normal: the HALT instruction enters IF/ID valid, is counted, and pc advances by 4.
  - halted <= 1 on that same edge.
  - From the following edge on, rule 1 applies: IF/ID drains to a bubble and pc freezes.
- No combinational path from stall/br_taken to pc or id_* outputs; all are registered. imem_addr depends only on the pc register.
- State summary: RUN (halted=0) and HALT (halted=1).
  - RUN->HALT on a HALT capture.
  - HALT->RUN only by reset.

Test Plan:
1. Reset then 4 normal cycles with imem returning 0x8B020020 at every address: pc=0,4,8,C,10; id_pc lags pc by one cycle (0,4,8,C); id_valid=1 from cycle 1; fetch_count=4.
2. Stall at pc=8 for 3 cycles: pc stays 8, id_pc stays 4, fetch_count unchanged; on release pc=C, id_pc=8.
3. br_taken=1 with br_target=0x103 at pc=10, stall=1 in the same cycle: next pc=0x100, id_valid=0, id_instr=D503201F; fetch_count unchanged; the following cycle pc=0x104, id_pc=0x100.
4. imem returns 14000000 at pc=0x20: next edge gives id_instr=14000000, id_valid=1, halted=1, pc=0x24. The edge after gives id_valid=0 and pc=0x24 frozen, with br_taken, stall and further edges ignored.
5. Reset asserted during HALT and during stall: next edge gives pc=0, halted=0, id_valid=0, fetch_count=0.
6. With br_target=FFFF_FFFF_FFFF_FFFC and CNT_WIDTH=2: after the redirect, the next normal fetch wraps pc to 0. Five normal captures leave fetch_count saturated at 3.
